// File: rtl/hyp_result_collector.sv
// Result sink for the batch-norm/hyperbolic accelerator: buffers {sinh,cosh} pairs
// in a show-ahead FIFO with batch tags and NaN/Inf flags, and tracks run completion.
module hyp_result_collector #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [10:0]                expected_count,
  input  logic                       clear,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       run_done,
  output logic                       done_pulse,
  output logic                       err_sticky
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned ENT_W = DATA_W + TAG_W + 4;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [10:0]         rx_count, rx_d, rx_inc;
  logic [10:0]         exp_reg, exp_d;
  logic                push, pop_eff;
  logic [3:0]          in_flags;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    head;

  logic [31:0] sinh_w, cosh_w;
  assign sinh_w = in_data[DATA_W-1 -: 32];
  assign cosh_w = in_data[31:0];

  assign in_flags[0] = (cosh_w[30:23] == 8'hFF) && (cosh_w[22:0] != '0);
  assign in_flags[1] = (cosh_w[30:23] == 8'hFF) && (cosh_w[22:0] == '0);
  assign in_flags[2] = (sinh_w[30:23] == 8'hFF) && (sinh_w[22:0] != '0);
  assign in_flags[3] = (sinh_w[30:23] == 8'hFF) && (sinh_w[22:0] == '0);

  assign in_ready  = !reset && (state_q != S_DONE) && (level != LVL_FULL);
  assign out_valid = (level != '0);
  assign run_done  = (state_q == S_DONE);
  assign push      = in_valid && in_ready && !clear;
  assign pop_eff   = pop && out_valid && !clear;
  assign rx_inc    = (rx_count == 11'h7FF) ? rx_count : rx_count + 11'd1;

  always_comb begin
    state_d = state_q;
    rx_d    = rx_count;
    exp_d   = exp_reg;
    case (state_q)
      S_IDLE: begin
        if (push) begin
          exp_d   = expected_count;
          rx_d    = 11'd1;
          state_d = (expected_count == 11'd1) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (push) begin
          rx_d = rx_inc;
          if ((exp_reg != '0) && (rx_inc == exp_reg)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (level == '0) begin
          state_d = S_IDLE;
          rx_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      rx_d    = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_count   <= '0;
      exp_reg    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      err_sticky <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_count   <= rx_d;
      exp_reg    <= exp_d;
      done_pulse <= (state_d == S_DONE) && (state_q != S_DONE);
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + AW'(1);
        if (pop_eff) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop_eff)      level <= level + (AW+1)'(1);
        else if (!push && pop_eff) level <= level - (AW+1)'(1);
        if (push && (in_flags != '0)) err_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_flags, rx_count[TAG_W-1:0], in_data};
  end

  // Head fields are forced to zero when empty so stale storage never shows.
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_tag   = out_valid ? head[DATA_W +: TAG_W] : '0;
  assign out_flags = out_valid ? head[DATA_W+TAG_W +: 4] : '0;

endmodule

// File: tb/tb_hyp_result_collector.sv
// Directed self-checking bench for hyp_result_collector: run completion, ordering,
// full/wrap behaviour, NaN/Inf flags, clear and asynchronous reset.
module tb_hyp_result_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, clear, pop;
  logic [63:0] in_data;
  logic [10:0] expected_count;
  logic        out_valid, run_done, done_pulse, err_sticky;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic [3:0]  out_flags;
  logic [5:0]  level;

  int pass_cnt = 0;
  int total_cnt = 0;

  hyp_result_collector #(.DEPTH(32), .DATA_W(64), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .expected_count(expected_count), .clear(clear), .pop(pop),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_flags(out_flags), .level(level), .run_done(run_done),
    .done_pulse(done_pulse), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] pat(input int i);
    logic [31:0] k;
    k = 32'(i);
    return {32'h3F800000 + k, 32'h40000000 + (k << 4)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; pop = 1'b0;
    in_data = '0; expected_count = '0;
    #12;
    total_cnt++;
    if ({out_valid, level, run_done, done_pulse, err_sticky, out_flags, out_tag} !== '0)
      $display("FAIL reset_ctrl got v=%b lvl=%0d rd=%b dp=%b err=%b exp all 0",
               out_valid, level, run_done, done_pulse, err_sticky);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 64'h0) $display("FAIL reset_data got %h exp 0", out_data);
    else pass_cnt++;
    @(negedge clock); reset = 1'b0;
    tick();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_run_done();
    expected_count = 11'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = pat(i);
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (done_pulse !== 1'b1) $display("FAIL done_pulse_rise got %b exp 1", done_pulse);
    else pass_cnt++;
    total_cnt++;
    if ({run_done, in_ready, level} !== {1'b1, 1'b0, 6'd5})
      $display("FAIL run_done_state got rd=%b rdy=%b lvl=%0d exp 1 0 5", run_done, in_ready, level);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done_pulse, run_done} !== 2'b01)
      $display("FAIL done_pulse_fall got dp=%b rd=%b exp 0 1", done_pulse, run_done);
    else pass_cnt++;
  endtask

  task automatic test_pop_order();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({out_valid, out_tag, out_data} !== {1'b1, 5'(i), pat(i)})
        $display("FAIL pop_order[%0d] got v=%b tag=%0d data=%h exp tag=%0d data=%h",
                 i, out_valid, out_tag, out_data, i, pat(i));
      else pass_cnt++;
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    tick();
    total_cnt++;
    if ({level, in_ready, run_done, out_valid} !== {6'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL after_pops got lvl=%0d rdy=%b rd=%b v=%b exp 0 1 0 0",
               level, in_ready, run_done, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    do_clear();
    expected_count = 11'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = pat(i);
      tick();
    end
    in_data = pat(32);
    total_cnt++;
    if ({level, in_ready} !== {6'd32, 1'b0})
      $display("FAIL full got lvl=%0d rdy=%b exp 32 0", level, in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (level !== 6'd32) $display("FAIL full_hold got lvl=%0d exp 32", level);
    else pass_cnt++;
    pop = 1'b1;
    tick();
    total_cnt++;
    if ({level, in_ready} !== {6'd31, 1'b1})
      $display("FAIL full_pop got lvl=%0d rdy=%b exp 31 1", level, in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    pop = 1'b0;
    total_cnt++;
    if (level !== 6'd31) $display("FAIL push_pop_same got lvl=%0d exp 31", level);
    else pass_cnt++;
    for (int i = 2; i < 33; i++) begin
      total_cnt++;
      if ({out_tag, out_data} !== {5'(i % 32), pat(i)})
        $display("FAIL wrap_head[%0d] got tag=%0d data=%h exp tag=%0d data=%h",
                 i, out_tag, out_data, i % 32, pat(i));
      else pass_cnt++;
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL wrap_empty got v=%b exp 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flags();
    do_clear();
    expected_count = 11'd0;
    in_valid = 1'b1;
    in_data = {32'h7FC00000, 32'h7F800000};
    tick();
    in_data = {32'h3F800000, 32'h40000000};
    total_cnt++;
    if ({out_valid, out_flags, err_sticky} !== {1'b1, 4'b0110, 1'b1})
      $display("FAIL nan_inf_flags got v=%b fl=%b err=%b exp 1 0110 1", out_valid, out_flags, err_sticky);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    total_cnt++;
    if ({out_flags, err_sticky, out_data} !== {4'b0000, 1'b1, 32'h3F800000, 32'h40000000})
      $display("FAIL clean_flags got fl=%b err=%b data=%h exp 0000 1 3f80000040000000",
               out_flags, err_sticky, out_data);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    do_clear();
    expected_count = 11'd0;
    in_valid = 1'b1;
    in_data = {32'h7F800001, 32'h0};
    tick();
    in_data = pat(1);
    tick();
    tick();
    total_cnt++;
    if ({level, err_sticky} !== {6'd3, 1'b1})
      $display("FAIL pre_clear got lvl=%0d err=%b exp 3 1", level, err_sticky);
    else pass_cnt++;
    clear = 1'b1; pop = 1'b1;
    tick();
    clear = 1'b0; pop = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if ({level, out_valid, err_sticky, run_done} !== '0)
      $display("FAIL clear got lvl=%0d v=%b err=%b rd=%b exp 0 0 0 0", level, out_valid, err_sticky, run_done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({level, in_ready} !== {6'd0, 1'b1})
      $display("FAIL clear_no_accept got lvl=%0d rdy=%b exp 0 1", level, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_clear();
    expected_count = 11'd5;
    in_valid = 1'b1;
    in_data = pat(7);
    tick();
    in_data = pat(8);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (level !== 6'd2) $display("FAIL pre_reset got lvl=%0d exp 2", level);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, level, run_done, done_pulse, err_sticky, out_flags, out_tag, out_data, in_ready} !== '0)
      $display("FAIL async_reset got v=%b lvl=%0d rd=%b dp=%b data=%h rdy=%b exp all 0",
               out_valid, level, run_done, done_pulse, out_data, in_ready);
    else pass_cnt++;
    tick();
    @(negedge clock); reset = 1'b0;
    tick();
    total_cnt++;
    if ({done_pulse, run_done, level, in_ready} !== {1'b0, 1'b0, 6'd0, 1'b1})
      $display("FAIL post_reset got dp=%b rd=%b lvl=%0d rdy=%b exp 0 0 0 1",
               done_pulse, run_done, level, in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_done();
    test_pop_order();
    test_full_wrap();
    test_flags();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
